// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle for the bit-serial adder.
// master drives operands and start; slave returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, sub, op_a, op_b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, sub, op_a, op_b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, one full-adder cell
// reused over WIDTH cycles, LSB first, carry held in a register.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             cout_q;
  logic             take;
  logic             last;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_c;

  assign take = bus.start && (state != RUN);
  assign last = (cnt == CW'(WIDTH - 1));

  assign fa_a = a_q[cnt];
  assign fa_b = b_q[cnt];
  assign fa_s = fa_a ^ fa_b ^ cy;
  assign fa_c = (fa_a & fa_b) | (fa_a & cy) | (fa_b & cy);

  // Next state: RUN ends on the last bit slot, new work only outside RUN.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == RUN): state_nx = last ? DONE : RUN;
      default:        state_nx = bus.start ? RUN : IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand capture and one serial bit slot per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      cout_q <= 1'b0;
    end else if (take) begin
      a_q <= bus.op_a;
      b_q <= bus.sub ? ~bus.op_b : bus.op_b;
      cy  <= bus.sub ? 1'b1 : bus.c_in;
      cnt <= '0;
    end else if (state == RUN) begin
      sum_q  <= {fa_s, sum_q[WIDTH-1:1]};
      cout_q <= fa_c;
      cy     <= fa_c;
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
REQ-006 op_a  input  WIDTH  operand A; sampled with start.
REQ-007 op_b  input  WIDTH  operand B; sampled with start.
REQ-008 c_in  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 c_out  output  1  final carry (add) or not-borrow (sub); held with sum.

Function
REQ-013 Block SHALL time-share one 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) over WIDTH cycles, LSB first, with a registered carry between bit slots.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> capture op_a, op_b, sub, c_in into shift registers; load bit counter 0; go to RUN.
REQ-016 Carry register load on start: c_in when sub=0; 1 when sub=1; B shift register loaded with ~op_b when sub=1, else op_b.
REQ-017 RUN: each cycle process bit [counter]: shift result bit into sum MSB-side shift register, update carry register, increment counter.
REQ-018 RUN -> DONE after exactly WIDTH RUN cycles (counter reaching WIDTH-1 on the processing edge).
REQ-019 DONE: done=1 for exactly one cycle; sum/c_out hold final values; next state IDLE, or RUN if start=1 (back-to-back accepted, with new capture as REQ-015/016).
REQ-020 busy SHALL be 1 in RUN, 0 in IDLE and DONE.
REQ-021 Latency: start sampled at edge T -> done high during cycle after edge T+WIDTH; busy high from edge T to edge T+WIDTH.
REQ-022 start while in RUN SHALL be ignored; no input change in RUN affects the operation in flight.
REQ-023 sum/c_out SHALL NOT change while in IDLE; they update only during RUN shifting and are final at DONE (intermediate values during RUN are don't-care to consumers).
REQ-024 Counter width SHALL be clog2(WIDTH), minimum 1 bit; no wrap beyond WIDTH-1.
REQ-025 Subtract: c_out=1 means no borrow (op_a >= op_b unsigned); sum = (op_a - op_b) mod 2^WIDTH.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, c_out=0, counter=0, carry register=0, regardless of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse for it after rst_n release.
REQ-028 First start accepted on the first rising clk edge with rst_n=1.

Verification
REQ-029 WIDTH=8, add 0x5A+0x3C, c_in=0 -> done 8 cycles after start cycle's next cycle per REQ-021, sum=0x96, c_out=0.
REQ-030 Add 0xFF+0x01, c_in=0 -> sum=0x00, c_out=1; add 0xFF+0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-031 Sub 0x20-0x10 -> sum=0x10, c_out=1; sub 0x10-0x20 -> sum=0xF0, c_out=0; c_in ignored (drive 1, same result).
REQ-032 Start pulsed during RUN with different operands -> ignored; single done with original result; busy high exactly 8 cycles.
REQ-033 rst_n low at RUN cycle 4 -> busy=0, sum=0x00, c_out=0 asynchronously; no done after release; next start yields correct result.
REQ-034 start held high continuously with new operands each DONE cycle -> back-to-back operations, done every 9 cycles, each result correct.
